detector_jogada: RTL and testbench
==================================

Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game datapath/control unit.
- Takes the four raw push-button lines and synchronises and debounces them.
- Validates one press and emits a single-cycle jogada_feita pulse with the registered 4-bit play code.
- Contains the inactivity timeout counter that the control unit reads as its timeout condition.

Parameters:
- DEBOUNCE_CYCLES, 10: consecutive stable cycles required to accept a press or a release (10 ms at 1 kHz).
- TIMEOUT_CYCLES, 5000: cycles without an accepted play before timeout asserts (5 s at 1 kHz).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock, asserted when 0.
- botoes  in  4  raw asynchronous button lines, active-high.
- conta_timeout  in  1  enables the timeout counter (control unit asserts it while waiting for a play).
- zera_timeout  in  1  synchronous clear of the timeout counter and timeout flag.
- jogada  out  4  one-hot code of the last accepted play; holds until the next accepted play.
- jogada_feita  out  1  one-cycle pulse when a play is accepted.
- tem_jogada  out  1  high while any synchronised button is high (raw level, for debug).
- timeout  out  1  inactivity timeout flag.
- db_estado  out  3  current FSM state encoding.

Behaviour:
- Reset (reset=0 at a rising edge):
  - FSM goes to ESPERA; synchroniser, debounce and timeout counters clear.
  - jogada=0000, jogada_feita=0, timeout=0, tem_jogada=0.
  - Reset wins over every other input.
- Synchroniser:
  - Two flip-flop stages per bit; the stage-2 value is b_s.
  - tem_jogada = OR of b_s, so it has 2-cycle latency from botoes.
- FSM states and encoding:
  - ESPERA=000: b_s==0. Go to FILTRA on b_s!=0, latching candidate=b_s and clearing the debounce count.
  - FILTRA=001:
    - If b_s!=candidate, return to ESPERA when b_s==0; otherwise relatch candidate and restart the count.
    - If the count reaches DEBOUNCE_CYCLES-1 with b_s==candidate, go to REGISTRA.
  - REGISTRA=010:
    - Exactly one cycle; jogada_feita=1 during this state.
    - If candidate is one-hot, jogada<=candidate. If it is not one-hot, see Optional Feature.
    - Always go to SEGURA.
  - SEGURA=011: stay while b_s!=0. On b_s==0, go to SOLTA, clearing the count.
  - SOLTA=100:
    - On any b_s!=0, return to SEGURA; bounce on release is ignored.
    - After DEBOUNCE_CYCLES consecutive zeros, go to ESPERA.
  - Unused encodings go to ESPERA.
- Latency:
  - A press steady from the edge where botoes changes at cycle k gives jogada_feita high during cycle k+2+DEBOUNCE_CYCLES (12 with defaults).
  - Holding the button never produces a second pulse.
- Timeout counter:
  - Width clog2(TIMEOUT_CYCLES+1).
  - Priority order: reset > zera_timeout > jogada_feita (clears counter and timeout) > conta_timeout (increments).
  - When the counter reaches TIMEOUT_CYCLES-1 while counting, timeout<=1 on the next edge.
  - The counter saturates and timeout stays 1 until cleared.
  - With conta_timeout=0 the counter holds its value.
  - Simultaneous zera_timeout and terminal count: the clear wins and timeout stays 0.
- Mid-operation reset: aborts any state with no jogada_feita pulse; a button still held after reset must be released and re-pressed to register (path ESPERA→FILTRA→…).

Optional Feature:
- Macro: JOGADA_INVALIDA_EN.
- Defined:
  - Extra output port jogada_invalida (1 bit).
  - In REGISTRA with a non-one-hot candidate: jogada_invalida=1 for that cycle, jogada_feita=0, jogada unchanged, timeout counter not cleared.
- Undefined:
  - Port absent.
  - A non-one-hot candidate is reduced to its lowest-index set bit (0110→0010), with a normal jogada_feita pulse.

Test Plan:
- Reset: hold reset=0 for 1 cycle with botoes=0101 → jogada=0000, jogada_feita=0, timeout=0, db_estado=000 after release.
- Clean press: botoes=0001 for 20 cycles, then 0000 → exactly one jogada_feita pulse 12 cycles after the edge, jogada=0001, db_estado back to 000 after 10 release cycles.
- Bounce: botoes toggles 0010/0000 every 3 cycles for 15 cycles, then steady 0010 → no pulse during toggling; one pulse 12 cycles after steady; jogada=0010.
- Timeout: conta_timeout=1, no presses for 5000 cycles → timeout=1 at cycle 5000 and stays; zera_timeout pulse → timeout=0 next cycle.
- Timeout cleared by play: conta_timeout=1 for 4000 cycles, press 0100 → counter clears on jogada_feita; no timeout before cycle 4012+5000.
- Multi-press 0110 held 20 cycles → with JOGADA_INVALIDA_EN: jogada_invalida pulse, jogada unchanged. Without it: jogada_feita pulse, jogada=0010.

Source files
------------

// File: rtl/detector_jogada_if.sv
// Button/play-detector signal bundle between the control unit (master) and detector_jogada (slave).
// JOGADA_INVALIDA_EN adds the jogada_invalida flag.
interface detector_jogada_if;
   logic [3:0] botoes;
   logic       conta_timeout;
   logic       zera_timeout;
   logic [3:0] jogada;
   logic       jogada_feita;
   logic       tem_jogada;
   logic       timeout;
   logic [2:0] db_estado;
`ifdef JOGADA_INVALIDA_EN
   logic       jogada_invalida;

   modport master (
      output botoes, conta_timeout, zera_timeout,
      input  jogada, jogada_feita, tem_jogada, timeout, db_estado, jogada_invalida
   );
   modport slave (
      input  botoes, conta_timeout, zera_timeout,
      output jogada, jogada_feita, tem_jogada, timeout, db_estado, jogada_invalida
   );
`else
   modport master (
      output botoes, conta_timeout, zera_timeout,
      input  jogada, jogada_feita, tem_jogada, timeout, db_estado
   );
   modport slave (
      input  botoes, conta_timeout, zera_timeout,
      output jogada, jogada_feita, tem_jogada, timeout, db_estado
   );
`endif
endinterface

// File: rtl/detector_jogada.sv
// Button synchroniser/debouncer with single-pulse play detection and inactivity timeout counter.
// Optional macro JOGADA_INVALIDA_EN flags multi-button presses instead of reducing them.
module detector_jogada #(
   parameter int unsigned DEBOUNCE_CYCLES = 10,
   parameter int unsigned TIMEOUT_CYCLES  = 5000
) (
   input logic               clock,
   input logic               reset,
   detector_jogada_if.slave  bus
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
   // First stable sample is taken in ESPERA/SEGURA, so the count stops one short.
   localparam logic [CntW-1:0] CntFim = CntW'(DEBOUNCE_CYCLES - 2);
   localparam logic [TW-1:0]   TFim   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]   TMax   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      StEspera   = 3'b000,
      StFiltra   = 3'b001,
      StRegistra = 3'b010,
      StSegura   = 3'b011,
      StSolta    = 3'b100
   } estado_t;

   estado_t          r_estado, w_estado_prox;
   logic [3:0]       r_sync1, r_sync2;
   logic [3:0]       r_cand, w_cand_prox;
   logic [CntW-1:0]  r_cnt, w_cnt_prox;
   logic [3:0]       r_jogada, w_jogada_prox;
   logic [1:0]       r_fill;
   logic             r_armado, w_armado_prox;
   logic [TW-1:0]    r_tcnt;
   logic             r_timeout;
   logic             w_feita;
   logic [3:0]       w_bs;
   logic             w_onehot;
   logic [3:0]       w_lowbit;
`ifdef JOGADA_INVALIDA_EN
   logic             w_invalida;
`endif

   assign w_bs     = r_sync2;
   assign w_onehot = (r_cand & (r_cand - 4'd1)) == 4'd0;
   assign w_lowbit = r_cand & (~r_cand + 4'd1);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sync1  <= 4'd0;
         r_sync2  <= 4'd0;
         r_fill   <= 2'd0;
         r_estado <= StEspera;
         r_cand   <= 4'd0;
         r_cnt    <= '0;
         r_jogada <= 4'd0;
         r_armado <= 1'b0;
      end else begin
         r_sync1  <= bus.botoes;
         r_sync2  <= r_sync1;
         if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
         r_estado <= w_estado_prox;
         r_cand   <= w_cand_prox;
         r_cnt    <= w_cnt_prox;
         r_jogada <= w_jogada_prox;
         r_armado <= w_armado_prox;
      end
   end

   always_comb begin
      w_estado_prox = r_estado;
      w_cand_prox   = r_cand;
      w_cnt_prox    = r_cnt;
      w_jogada_prox = r_jogada;
      w_armado_prox = r_armado;
      w_feita       = 1'b0;
`ifdef JOGADA_INVALIDA_EN
      w_invalida    = 1'b0;
`endif
      case (r_estado)
         StEspera: begin
            // After reset a button must be seen released before a press can count.
            if (!r_armado) begin
               if (r_fill == 2'd2 && w_bs == 4'd0) w_armado_prox = 1'b1;
            end else if (w_bs != 4'd0) begin
               w_estado_prox = StFiltra;
               w_cand_prox   = w_bs;
               w_cnt_prox    = '0;
            end
         end
         StFiltra: begin
            if (w_bs != r_cand) begin
               if (w_bs == 4'd0) begin
                  w_estado_prox = StEspera;
               end else begin
                  w_cand_prox = w_bs;
                  w_cnt_prox  = '0;
               end
            end else if (r_cnt == CntFim) begin
               w_estado_prox = StRegistra;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         StRegistra: begin
            w_estado_prox = StSegura;
            if (w_onehot) begin
               w_feita       = 1'b1;
               w_jogada_prox = r_cand;
            end else begin
`ifdef JOGADA_INVALIDA_EN
               w_invalida    = 1'b1;
`else
               w_feita       = 1'b1;
               w_jogada_prox = w_lowbit;
`endif
            end
         end
         StSegura: begin
            if (w_bs == 4'd0) begin
               w_estado_prox = StSolta;
               w_cnt_prox    = '0;
            end
         end
         StSolta: begin
            if (w_bs != 4'd0) begin
               w_estado_prox = StSegura;
            end else if (r_cnt == CntFim) begin
               w_estado_prox = StEspera;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         default: w_estado_prox = StEspera;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else if (bus.zera_timeout || w_feita) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else if (bus.conta_timeout) begin
         if (r_tcnt == TFim) r_timeout <= 1'b1;
         if (r_tcnt != TMax) r_tcnt <= r_tcnt + 1'b1;
      end
   end

   assign bus.jogada       = r_jogada;
   assign bus.jogada_feita = w_feita;
   assign bus.tem_jogada   = |w_bs;
   assign bus.timeout      = r_timeout;
   assign bus.db_estado    = r_estado;
`ifdef JOGADA_INVALIDA_EN
   assign bus.jogada_invalida = w_invalida;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada: expected plays are queued at the press and matched on
// each jogada_feita pulse (cycle and code); timeout and FSM state are checked directly.
module tb_detector_jogada;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;

   logic clock;
   logic reset;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   n_inval;
   logic [3:0] last_code;
   exp_t sb_q[$];

   detector_jogada_if bus ();

   detector_jogada dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clock);
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      else n_pass++;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) step(1);
   endtask

   // Press, hold, release and let the release debounce finish.
   task automatic press(input logic [3:0] code, input logic [3:0] exp_code, input bit expect_pulse,
                        input int hold);
      bus.botoes = code;
      if (expect_pulse) begin
         sb_q.push_back('{exp_code, cyc + 12});
         last_code = exp_code;
      end
      step(hold);
      bus.botoes = 4'd0;
      step(15);
   endtask

   // Output monitor: pulses are popped from the scoreboard, jogada is checked the cycle after.
   initial begin
      logic       pend;
      logic [3:0] pend_code;
      exp_t       e;
      pend = 1'b0;
      pend_code = 4'd0;
      forever begin
         @(negedge clock);
         if (pend) begin
            check("jogada_apos_pulso", 32'(bus.jogada), 32'(pend_code));
            pend = 1'b0;
         end
         if (bus.jogada_feita === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("pulso_inesperado", 32'(1), 32'(0));
            end else begin
               e = sb_q.pop_front();
               check("latencia_pulso", 32'(cyc), 32'(e.cyc));
               pend      = 1'b1;
               pend_code = e.code;
            end
         end
`ifdef JOGADA_INVALIDA_EN
         if (bus.jogada_invalida === 1'b1) n_inval++;
`endif
      end
   end

   initial begin
      int t0;
      int k;
      n_checks = 0;
      n_pass = 0;
      n_inval = 0;
      last_code = 4'd0;
      reset = 1'b0;
      bus.botoes = 4'b0101;
      bus.conta_timeout = 1'b0;
      bus.zera_timeout = 1'b0;

      // Reset
      step(2);
      check("rst_jogada", 32'(bus.jogada), 32'(0));
      check("rst_feita", 32'(bus.jogada_feita), 32'(0));
      check("rst_timeout", 32'(bus.timeout), 32'(0));
      check("rst_estado", 32'(bus.db_estado), 32'(0));
      check("rst_tem_jogada", 32'(bus.tem_jogada), 32'(0));
      reset = 1'b1;
      bus.botoes = 4'd0;
      step(1);
      check("rst_estado_apos", 32'(bus.db_estado), 32'(0));
      step(5);

      // Clean press with synchroniser latency and release timing
      bus.botoes = 4'b0001;
      sb_q.push_back('{4'b0001, cyc + 12});
      last_code = 4'b0001;
      step(1);
      check("tem_jogada_lat1", 32'(bus.tem_jogada), 32'(0));
      step(1);
      check("tem_jogada_lat2", 32'(bus.tem_jogada), 32'(1));
      step(38);
      check("estado_segura", 32'(bus.db_estado), 32'(3));
      bus.botoes = 4'd0;
      step(11);
      check("estado_solta", 32'(bus.db_estado), 32'(4));
      step(1);
      check("estado_espera", 32'(bus.db_estado), 32'(0));
      step(5);

      // Bouncing press, then steady
      for (int i = 0; i < 6; i++) begin
         bus.botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         step(3);
      end
      press(4'b0010, 4'b0010, 1'b1, 20);
      check("jogada_bounce", 32'(bus.jogada), 32'(4'b0010));

      // Reset mid-filter: held button must be released before it counts
      bus.botoes = 4'b1000;
      step(6);
      reset = 1'b0;
      step(1);
      check("midrst_estado", 32'(bus.db_estado), 32'(0));
      check("midrst_jogada", 32'(bus.jogada), 32'(0));
      reset = 1'b1;
      step(30);
      check("midrst_segurado", 32'(bus.db_estado), 32'(0));
      bus.botoes = 4'd0;
      step(10);
      last_code = 4'd0;
      press(4'b1000, 4'b1000, 1'b1, 20);
      check("jogada_repress", 32'(bus.jogada), 32'(4'b1000));

      // Multi-button press
`ifdef JOGADA_INVALIDA_EN
      k = n_inval;
      press(4'b0110, 4'b0000, 1'b0, 20);
      check("invalida_pulso", 32'(n_inval), 32'(k + 1));
      check("invalida_jogada", 32'(bus.jogada), 32'(last_code));
`else
      k = 0;
      press(4'b0110, 4'b0010, 1'b1, 20);
      check("multi_jogada", 32'(bus.jogada), 32'(4'b0010));
`endif

      // Timeout from idle counting
      bus.zera_timeout = 1'b1;
      step(1);
      bus.zera_timeout = 1'b0;
      bus.conta_timeout = 1'b1;
      t0 = cyc;
      step_to(t0 + 4999);
      check("timeout_antes", 32'(bus.timeout), 32'(0));
      step(1);
      check("timeout_em", 32'(bus.timeout), 32'(1));
      step(50);
      check("timeout_satura", 32'(bus.timeout), 32'(1));
      bus.zera_timeout = 1'b1;
      step(1);
      check("timeout_zera", 32'(bus.timeout), 32'(0));
      bus.zera_timeout = 1'b0;

      // Timeout restarted by an accepted play
      bus.zera_timeout = 1'b1;
      step(1);
      bus.zera_timeout = 1'b0;
      t0 = cyc;
      step_to(t0 + 4000);
      bus.botoes = 4'b0100;
      sb_q.push_back('{4'b0100, cyc + 12});
      step(20);
      bus.botoes = 4'd0;
      step_to(t0 + 5000);
      check("timeout_limpo_jogada", 32'(bus.timeout), 32'(0));
      check("jogada_0100", 32'(bus.jogada), 32'(4'b0100));
      step_to(t0 + 9012);
      check("timeout_antes2", 32'(bus.timeout), 32'(0));
      step(1);
      check("timeout_em2", 32'(bus.timeout), 32'(1));
      bus.conta_timeout = 1'b0;
      step(5);
      check("timeout_retido", 32'(bus.timeout), 32'(1));

      step(5);
      check("scoreboard_vazio", 32'(sb_q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
